vc_demux_pause: RTL and testbench

VC_DEMUX_PAUSE -- requirements
Module: vc_demux_pause

---
 rtl/vc_demux_pause.sv | 154 +++++++++++++++
 tb/tb_vc_demux_pause.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/vc_demux_pause.sv
// Per-VC FIFO: circular buffer with registered occupancy, read data and drop flag.
// Latency: write lands on the valid edge; popped word appears registered one cycle later.
// Backpressure: pause from registered count >= AF_THRESH; a push while full is dropped.
module vc_demux_pause_fifo #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  rvalid_o,
    output logic                  pause_o,
    output logic                  empty_o,
    output logic                  drop_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  full, empty, do_push, do_pop;

    // Full/empty come from the registered count only, so a same-cycle pop
    // never makes room for a push and a same-cycle push never feeds a pop.
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign do_push = push_i & ~full;
    assign do_pop  = pop_i & ~empty;

    // Next-state for pointers, occupancy and the registered read port.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        rdata_d  = rdata_q;
        rvalid_d = do_pop;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            rdata_d  = mem_q[rd_ptr_q];
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Storage array; contents are don't-care after reset since pointers clear.
    always_ff @(posedge clk) begin
        if (!reset && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign pause_o  = (count_q >= AF_C);
    assign empty_o  = empty;
    assign drop_o   = push_i & full;
endmodule

// Two-VC demux: routes popped main-FIFO words by MSB into per-VC FIFOs.
// Latency: store on the valid edge; read data registered, one cycle after pop.
// Backpressure: per-VC pause from registered count; overflow drops and sets sticky error.
module vc_demux_pause #(
    parameter int DATA_WIDTH = 6,
    parameter int DEPTH      = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop_vc0,
    input  logic                  pop_vc1,
    output logic [DATA_WIDTH-1:0] vc0_data_out,
    output logic [DATA_WIDTH-1:0] vc1_data_out,
    output logic                  vc0_valid_out,
    output logic                  vc1_valid_out,
    output logic                  pause_vc0,
    output logic                  pause_vc1,
    output logic                  empty_vc0,
    output logic                  empty_vc1,
    output logic                  error_out
);
    logic push_vc0, push_vc1;
    logic drop_vc0, drop_vc1;
    logic error_q, error_d;

    assign push_vc0 = valid_in & ~data_in[DATA_WIDTH-1];
    assign push_vc1 = valid_in &  data_in[DATA_WIDTH-1];

    vc_demux_pause_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)
    ) u_vc0 (
        .clk(clk), .reset(reset), .push_i(push_vc0), .pop_i(pop_vc0),
        .wdata_i(data_in), .rdata_o(vc0_data_out), .rvalid_o(vc0_valid_out),
        .pause_o(pause_vc0), .empty_o(empty_vc0), .drop_o(drop_vc0)
    );

    vc_demux_pause_fifo #(
        .DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)
    ) u_vc1 (
        .clk(clk), .reset(reset), .push_i(push_vc1), .pop_i(pop_vc1),
        .wdata_i(data_in), .rdata_o(vc1_data_out), .rvalid_o(vc1_valid_out),
        .pause_o(pause_vc1), .empty_o(empty_vc1), .drop_o(drop_vc1)
    );

    // Overflow flag is sticky: once any VC drops a word it stays set until reset.
    always_comb begin
        error_d = error_q | drop_vc0 | drop_vc1;
    end

    // Error register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_out = error_q;
endmodule

// File: tb/tb_vc_demux_pause.sv
// Bench for vc_demux_pause: directed vector table, multi-cycle corner sequences,
// then random traffic compared against a queue-based reference model.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_vc_demux_pause;
    localparam int DW    = 6;
    localparam int DEPTH = 4;
    localparam int AF    = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          pop_vc0 = 1'b0;
    logic          pop_vc1 = 1'b0;
    logic [DW-1:0] vc0_data_out, vc1_data_out;
    logic          vc0_valid_out, vc1_valid_out;
    logic          pause_vc0, pause_vc1, empty_vc0, empty_vc1, error_out;

    int checks   = 0;
    int failures = 0;

    // Reference model state: one queue per VC plus expected output registers.
    logic [DW-1:0] mq0[$];
    logic [DW-1:0] mq1[$];
    logic          m_err = 1'b0;
    logic          m_v0 = 1'b0, m_v1 = 1'b0;
    logic [DW-1:0] m_d0 = '0, m_d1 = '0;

    typedef struct {
        logic          rst, vld;
        logic [DW-1:0] dat;
        logic          p0, p1;
        logic          ev0;
        logic [DW-1:0] ed0;
        logic          ev1;
        logic [DW-1:0] ed1;
        logic          ep0, ep1, ee0, ee1, eerr;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    vc_demux_pause #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_THRESH(AF)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .data_in(data_in),
        .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
        .vc0_data_out(vc0_data_out), .vc1_data_out(vc1_data_out),
        .vc0_valid_out(vc0_valid_out), .vc1_valid_out(vc1_valid_out),
        .pause_vc0(pause_vc0), .pause_vc1(pause_vc1),
        .empty_vc0(empty_vc0), .empty_vc1(empty_vc1), .error_out(error_out)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic v, input logic [DW-1:0] d,
                       input logic a, input logic b,
                       input logic ev0, input logic [DW-1:0] ed0,
                       input logic ev1, input logic [DW-1:0] ed1,
                       input logic ep0, input logic ep1,
                       input logic ee0, input logic ee1, input logic er);
        vec_t t;
        t.rst = r; t.vld = v; t.dat = d; t.p0 = a; t.p1 = b;
        t.ev0 = ev0; t.ed0 = ed0; t.ev1 = ev1; t.ed1 = ed1;
        t.ep0 = ep0; t.ep1 = ep1; t.ee0 = ee0; t.ee1 = ee1; t.eerr = er;
        tbl.push_back(t);
    endtask

    // One clock: drive inputs, advance the model from the same inputs, compare.
    task automatic step(input logic r, input logic v, input logic [DW-1:0] d,
                        input logic a, input logic b);
        bit full0, full1;
        reset = r; valid_in = v; data_in = d; pop_vc0 = a; pop_vc1 = b;
        @(posedge clk);
        #1;
        if (r) begin
            mq0.delete(); mq1.delete();
            m_err = 1'b0; m_v0 = 1'b0; m_v1 = 1'b0; m_d0 = '0; m_d1 = '0;
        end else begin
            full0 = (mq0.size() == DEPTH);
            full1 = (mq1.size() == DEPTH);
            m_v0 = a && (mq0.size() > 0);
            m_v1 = b && (mq1.size() > 0);
            if (m_v0) m_d0 = mq0.pop_front();
            if (m_v1) m_d1 = mq1.pop_front();
            if (v) begin
                if (d[DW-1] ? full1 : full0) m_err = 1'b1;
                else if (d[DW-1]) mq1.push_back(d);
                else mq0.push_back(d);
            end
        end
        chk("model_v0", vc0_valid_out, m_v0);
        chk("model_d0", vc0_data_out, m_d0);
        chk("model_v1", vc1_valid_out, m_v1);
        chk("model_d1", vc1_data_out, m_d1);
        chk("model_pause0", pause_vc0, mq0.size() >= AF);
        chk("model_pause1", pause_vc1, mq1.size() >= AF);
        chk("model_empty0", empty_vc0, mq0.size() == 0);
        chk("model_empty1", empty_vc1, mq1.size() == 0);
        chk("model_err", error_out, m_err);
    endtask

    initial begin
        // rst vld dat   p0 p1  ev0 ed0   ev1 ed1   ep0 ep1 ee0 ee1 err
        add(1, 0, 6'h00, 0, 0,  0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 0);
        // routing
        add(0, 1, 6'h05, 0, 0,  0, 6'h00, 0, 6'h00, 0, 0, 0, 1, 0);
        add(0, 1, 6'h25, 0, 0,  0, 6'h00, 0, 6'h00, 0, 0, 0, 0, 0);
        add(0, 0, 6'h00, 1, 0,  1, 6'h05, 0, 6'h00, 0, 0, 1, 0, 0);
        add(0, 0, 6'h00, 0, 1,  0, 6'h05, 1, 6'h25, 0, 0, 1, 1, 0);
        // pause on VC0
        add(0, 1, 6'h01, 0, 0,  0, 6'h05, 0, 6'h25, 0, 0, 0, 1, 0);
        add(0, 1, 6'h02, 0, 0,  0, 6'h05, 0, 6'h25, 0, 0, 0, 1, 0);
        add(0, 1, 6'h03, 0, 0,  0, 6'h05, 0, 6'h25, 1, 0, 0, 1, 0);
        add(0, 0, 6'h00, 1, 0,  1, 6'h01, 0, 6'h25, 0, 0, 0, 1, 0);
        add(0, 0, 6'h00, 1, 0,  1, 6'h02, 0, 6'h25, 0, 0, 0, 1, 0);
        add(0, 0, 6'h00, 1, 0,  1, 6'h03, 0, 6'h25, 0, 0, 1, 1, 0);
        // empty: ignored pop, then push+pop on empty (no fall-through)
        add(0, 0, 6'h00, 1, 0,  0, 6'h03, 0, 6'h25, 0, 0, 1, 1, 0);
        add(0, 1, 6'h0A, 1, 0,  0, 6'h03, 0, 6'h25, 0, 0, 0, 1, 0);
        add(0, 0, 6'h00, 1, 0,  1, 6'h0A, 0, 6'h25, 0, 0, 1, 1, 0);
        // overflow on VC1: fourth write after pause still fits, fifth drops
        add(0, 1, 6'h21, 0, 0,  0, 6'h0A, 0, 6'h25, 0, 0, 1, 0, 0);
        add(0, 1, 6'h22, 0, 0,  0, 6'h0A, 0, 6'h25, 0, 0, 1, 0, 0);
        add(0, 1, 6'h23, 0, 0,  0, 6'h0A, 0, 6'h25, 0, 1, 1, 0, 0);
        add(0, 1, 6'h24, 0, 0,  0, 6'h0A, 0, 6'h25, 0, 1, 1, 0, 0);
        add(0, 1, 6'h25, 0, 0,  0, 6'h0A, 0, 6'h25, 0, 1, 1, 0, 1);
        add(0, 0, 6'h00, 0, 1,  0, 6'h0A, 1, 6'h21, 0, 1, 1, 0, 1);
        add(0, 0, 6'h00, 0, 1,  0, 6'h0A, 1, 6'h22, 0, 0, 1, 0, 1);
        add(0, 0, 6'h00, 0, 1,  0, 6'h0A, 1, 6'h23, 0, 0, 1, 0, 1);
        add(0, 0, 6'h00, 0, 1,  0, 6'h0A, 1, 6'h24, 0, 0, 1, 1, 1);
        // reset mid-operation with contents and error set
        add(0, 1, 6'h07, 0, 0,  0, 6'h0A, 0, 6'h24, 0, 0, 0, 1, 1);
        add(0, 1, 6'h08, 0, 0,  0, 6'h0A, 0, 6'h24, 0, 0, 0, 1, 1);
        add(1, 0, 6'h00, 1, 1,  0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 0);
        add(0, 0, 6'h00, 1, 0,  0, 6'h00, 0, 6'h00, 0, 0, 1, 1, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].p0, tbl[i].p1);
            chk($sformatf("row%0d_v0", i), vc0_valid_out, tbl[i].ev0);
            chk($sformatf("row%0d_d0", i), vc0_data_out, tbl[i].ed0);
            chk($sformatf("row%0d_v1", i), vc1_valid_out, tbl[i].ev1);
            chk($sformatf("row%0d_d1", i), vc1_data_out, tbl[i].ed1);
            chk($sformatf("row%0d_pause0", i), pause_vc0, tbl[i].ep0);
            chk($sformatf("row%0d_pause1", i), pause_vc1, tbl[i].ep1);
            chk($sformatf("row%0d_empty0", i), empty_vc0, tbl[i].ee0);
            chk($sformatf("row%0d_empty1", i), empty_vc1, tbl[i].ee1);
            chk($sformatf("row%0d_err", i), error_out, tbl[i].eerr);
        end

        // Pointer wrap: interleaved push/pop keeps occupancy at 1.
        step(0, 1, 6'h00, 0, 0);
        for (int i = 1; i < 10; i++) begin
            step(0, 1, 6'(i), 1, 0);
            chk("wrap_valid", vc0_valid_out, 1);
            chk("wrap_data", vc0_data_out, i - 1);
            chk("wrap_not_empty", empty_vc0, 0);
            chk("wrap_no_pause", pause_vc0, 0);
        end
        step(0, 0, 6'h00, 1, 0);
        chk("wrap_last", vc0_data_out, 6'h09);
        chk("wrap_drained", empty_vc0, 1);

        // Push into a full FIFO with a same-cycle pop: push is still dropped.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 6'(8'h11 + i), 0, 0);
        step(0, 1, 6'h15, 1, 0);
        chk("fullpop_data", vc0_data_out, 6'h11);
        chk("fullpop_err", error_out, 1);
        chk("fullpop_pause", pause_vc0, 1);
        for (int i = 0; i < DEPTH - 1; i++) begin
            step(0, 0, 6'h00, 1, 0);
            chk("fullpop_drain", vc0_data_out, 6'(8'h12 + i));
        end
        step(0, 0, 6'h00, 1, 0);
        chk("fullpop_no_extra", vc0_valid_out, 0);
        chk("fullpop_err_sticky", error_out, 1);

        // Random traffic against the model, with occasional resets.
        step(1, 0, 6'h00, 0, 0);
        for (int n = 0; n < 3000; n++) begin
            step($urandom_range(0, 299) == 0,
                 $urandom_range(0, 2) != 0,
                 6'($urandom),
                 $urandom_range(0, 99) < 40,
                 $urandom_range(0, 99) < 40);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
